// File: rtl/martimed_pkg.sv
// Shared types and helpers for the martimed timed-output FIFO.
// The entry struct here describes the default-width layout; the top rebuilds it at its own widths.
package martimed_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DELAY_W = 7;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } engine_state_e;

    typedef struct packed {
        logic [DEF_DELAY_W-1:0] delay;
        logic [DEF_DATA_W-1:0]  data;
    } entry_t;

    function automatic int level_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/martimed_ram.sv
// Simple dual-port DEPTH x WIDTH storage: synchronous write.
// The read port is either combinational or registered, selected by REG_RD.
module martimed_ram #(
    parameter int WIDTH  = 23,
    parameter int DEPTH  = 4,
    parameter int REG_RD = 0
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    generate
        if (REG_RD != 0) begin : g_reg_rd
            logic [WIDTH-1:0] r_q;
            always_ff @(posedge i_clk) begin
                r_q <= r_mem[i_raddr];
            end
            assign o_rdata = r_q;
        end else begin : g_comb_rd
            assign o_rdata = r_mem[i_raddr];
        end
    endgenerate

endmodule

// File: rtl/martimed_fifo.sv
// Timed-output FIFO: each entry's data is strobed out its delay plus one cycle after the previous output.
// Define MARTIMED_DIRECT_EN to build the direct pass-through path and its collision detection.
module martimed_fifo
    import martimed_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 7,
    parameter int DEPTH   = 4,
    parameter int AFULL   = DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           data_i,
    input  logic [DELAY_W-1:0]          delay_i,
    input  logic                        valid_i,
    input  logic                        direct_i,
    input  logic                        halt_i,
    output logic [DATA_W-1:0]           data_o,
    output logic                        stb_o,
    output logic [level_w(DEPTH)-1:0]   level_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        afull_o,
    output logic                        err_o,
    output engine_state_e               dbg_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam int EW = DELAY_W + DATA_W;

    typedef struct packed {
        logic [DELAY_W-1:0] delay;
        logic [DATA_W-1:0]  data;
    } fifo_entry_t;

    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]      r_level, w_level_nxt;
    logic               r_empty, r_full, r_afull, r_err;
    engine_state_e      r_state, w_state_nxt;
    logic [DELAY_W-1:0] r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]  r_held, w_held_nxt;
    logic [DATA_W-1:0]  r_last, w_data_out;
    logic               w_push, w_pop, w_fire, w_stb, w_collide;
    logic               w_dir_stb;
    logic [DATA_W-1:0]  w_dir_data;
    logic [EW-1:0]      w_rd_word;
    fifo_entry_t        w_head, w_wr_entry;

    assign w_wr_entry = {delay_i, data_i};
    assign w_head     = w_rd_word;
    // Writes are gated by the registered full flag, so a same-cycle pop cannot rescue them.
    assign w_push     = valid_i & ~r_full;

    martimed_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .REG_RD(0)
    ) u_ram (
        .i_clk  (clk),
        .i_we   (w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(w_wr_entry),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_rd_word)
    );

`ifdef MARTIMED_DIRECT_EN
    logic              r_dir_stb;
    logic [DATA_W-1:0] r_dir_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir_stb  <= 1'b0;
            r_dir_data <= '0;
        end else begin
            r_dir_stb  <= direct_i;
            r_dir_data <= data_i;
        end
    end

    assign w_dir_stb  = r_dir_stb;
    assign w_dir_data = r_dir_data;
`else
    logic w_unused_direct;
    assign w_unused_direct = direct_i;
    assign w_dir_stb       = 1'b0;
    assign w_dir_data      = '0;
`endif

    // Read engine: IDLE waits for an entry, RUN counts the held entry's delay down to its strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_held_nxt  = r_held;
        w_pop       = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!r_empty && !halt_i) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = w_head.delay;
                    w_held_nxt  = w_head.data;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!halt_i) begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - DELAY_W'(1);
                    end else begin
                        w_fire = 1'b1;
                        if (!r_empty) begin
                            w_pop      = 1'b1;
                            w_cnt_nxt  = w_head.delay;
                            w_held_nxt = w_head.data;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_held  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_held  <= w_held_nxt;
        end
    end

    // A direct output pre-empts a coinciding timed strobe; the timed entry is still consumed.
    assign w_stb     = w_fire | w_dir_stb;
    assign w_collide = w_fire & w_dir_stb;

    always_comb begin
        w_data_out = r_last;
        if (w_dir_stb) begin
            w_data_out = w_dir_data;
        end else if (w_fire) begin
            w_data_out = r_held;
        end
    end

    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_afull  <= 1'b0;
            r_err    <= 1'b0;
            r_last   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_empty <= (w_level_nxt == '0);
            r_full  <= (w_level_nxt == LW'(DEPTH));
            r_afull <= (w_level_nxt >= LW'(AFULL));
            r_err   <= (valid_i & r_full) | w_collide;
            if (w_stb) begin
                r_last <= w_data_out;
            end
        end
    end

    assign data_o      = w_data_out;
    assign stb_o       = w_stb;
    assign level_o     = r_level;
    assign empty_o     = r_empty;
    assign full_o      = r_full;
    assign afull_o     = r_afull;
    assign err_o       = r_err;
    assign dbg_state_o = r_state;

endmodule
